// File: rtl/jtkiwi_paldma.sv
// Palette upload engine: copies 2**AW source bytes into the palette RAM write port, only during vertical blank.
// Optional JTKIWI_PALDMA_CHKSUM_EN adds a running modulo-256 checksum output of the written bytes.
module jtkiwi_paldma #(
  parameter int unsigned             AW       = 10,
  parameter int unsigned             SRC_AW   = 17,
  parameter logic [SRC_AW-1:0]       SRC_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LVBL,
  input  logic              dma_go,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_cs,
  input  logic              src_ok,
  input  logic [7:0]        src_data,
  output logic [AW-1:0]     pal_addr,
  output logic [7:0]        pal_dout,
  output logic              pal_we,
  output logic              busy,
  output logic              done
`ifdef JTKIWI_PALDMA_CHKSUM_EN
  ,
  output logic [7:0]        chksum
`endif
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_inc;
  logic [SRC_AW-1:0]   src_addr_q;
  logic                src_cs_q;
  logic [AW-1:0]       pal_addr_q;
  logic [7:0]          pal_dout_q;
  logic                pal_we_q;
  logic                busy_q;
  logic                done_q;
  logic [SRC_AW-1:0]   addr_cur;
  logic [SRC_AW-1:0]   addr_inc;

  // Source address is the base plus the index, wrapping within SRC_AW bits
  assign cnt_inc  = cnt_q + CW'(1);
  assign addr_cur = SRC_BASE + SRC_AW'(cnt_q);
  assign addr_inc = SRC_BASE + SRC_AW'(cnt_inc);

`ifdef JTKIWI_PALDMA_CHKSUM_EN
  logic [7:0] chksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum_q <= 8'd0;
    end else if (state_q == ST_IDLE && dma_go) begin
      chksum_q <= 8'd0;
    end else if (state_q == ST_WRITE) begin
      chksum_q <= chksum_q + pal_dout_q;
    end
  end

  assign chksum = chksum_q;
`endif

  // Transfer FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      src_addr_q <= SRC_BASE;
      src_cs_q   <= 1'b0;
      pal_addr_q <= '0;
      pal_dout_q <= 8'd0;
      pal_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pal_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dma_go) begin
            state_q <= ST_ARMED;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!LVBL) begin
            state_q    <= ST_READ;
            src_cs_q   <= 1'b1;
            src_addr_q <= addr_cur;
          end
        end
        ST_READ: begin
          // An in-flight request always completes, even if blanking ends meanwhile
          if (src_ok) begin
            state_q    <= ST_WRITE;
            src_cs_q   <= 1'b0;
            pal_dout_q <= src_data;
            pal_addr_q <= cnt_q[AW-1:0];
            pal_we_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          cnt_q <= cnt_inc;
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!LVBL) begin
            state_q    <= ST_READ;
            src_cs_q   <= 1'b1;
            src_addr_q <= addr_inc;
          end else begin
            state_q <= ST_ARMED;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_addr = src_addr_q;
  assign src_cs   = src_cs_q;
  assign pal_addr = pal_addr_q;
  assign pal_dout = pal_dout_q;
  assign pal_we   = pal_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_jtkiwi_paldma.sv
// Scoreboard bench for jtkiwi_paldma: expected palette writes are queued at arm time and popped on each pal_we.
module tb_jtkiwi_paldma;

  localparam int unsigned AW     = 10;
  localparam int unsigned SRC_AW = 17;
  localparam logic [SRC_AW-1:0] BASE = 17'h1FF00;
  localparam int NBYTES = 1 << AW;

  logic              clk;
  logic              rst_n;
  logic              LVBL;
  logic              dma_go;
  logic [SRC_AW-1:0] src_addr;
  logic              src_cs;
  logic              src_ok;
  logic [7:0]        src_data;
  logic [AW-1:0]     pal_addr;
  logic [7:0]        pal_dout;
  logic              pal_we;
  logic              busy;
  logic              done;
`ifdef JTKIWI_PALDMA_CHKSUM_EN
  logic [7:0]        chksum;
`endif

  jtkiwi_paldma #(.AW(AW), .SRC_AW(SRC_AW), .SRC_BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .LVBL     (LVBL),
    .dma_go   (dma_go),
    .src_addr (src_addr),
    .src_cs   (src_cs),
    .src_ok   (src_ok),
    .src_data (src_data),
    .pal_addr (pal_addr),
    .pal_dout (pal_dout),
    .pal_we   (pal_we),
    .busy     (busy),
    .done     (done)
`ifdef JTKIWI_PALDMA_CHKSUM_EN
    ,
    .chksum   (chksum)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  exp_sum;
  int req_idx  = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int dly      = 0;
  bit spurious = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full palette image: byte i = i[7:0]
  task automatic load_exp();
    exp_q.delete();
    exp_sum = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      exp_q.push_back({10'(i), 8'(i)});
      exp_sum = exp_sum + 8'(i);
    end
    req_idx = 0;
    wr_cnt  = 0;
  endtask

  task automatic arm();
    load_exp();
    @(negedge clk);
    dma_go = 1'b1;
    @(negedge clk);
    dma_go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Source memory model: byte at address a is a[7:0]; optional wait states and stray src_ok
  initial begin
    int w;
    logic [SRC_AW-1:0] ea;
    w = 0;
    src_ok = 1'b0;
    src_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        src_ok = 1'b0;
        w = 0;
      end else if (src_cs) begin
        ea = SRC_AW'(BASE + SRC_AW'(req_idx));
        check("src_addr", 32'(src_addr), 32'(ea));
        if (w >= dly) begin
          src_ok   = 1'b1;
          src_data = src_addr[7:0];
          req_idx++;
          w = 0;
        end else begin
          src_ok = 1'b0;
          w++;
        end
      end else begin
        src_ok   = spurious;
        src_data = 8'hA5;
        w = 0;
      end
    end
  end

  // Output monitor: every pal_we must match the head of the scoreboard
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && pal_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pal_addr", 32'(pal_addr), 32'(e[17:8]));
          check("pal_dout", 32'(pal_dout), 32'(e[7:0]));
          wr_cnt++;
        end
      end
      if (rst_n && done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'd0);
        check("queue_left_at_done", 32'(exp_q.size()), 32'd0);
`ifdef JTKIWI_PALDMA_CHKSUM_EN
        check("chksum", 32'(chksum), 32'(exp_sum));
`endif
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int bad;
    int d0;
    rst_n  = 1'b0;
    LVBL   = 1'b1;
    dma_go = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_src_addr", 32'(src_addr), 32'(BASE));
    check("rst_src_cs",   32'(src_cs),   32'd0);
    check("rst_pal_addr", 32'(pal_addr), 32'd0);
    check("rst_pal_dout", 32'(pal_dout), 32'd0);
    check("rst_pal_we",   32'(pal_we),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full copy in blank, zero-wait source, latency from dma_go edge to done
    LVBL = 1'b0;
    load_exp();
    @(negedge clk);
    dma_go = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    dma_go = 1'b0;
    check("busy_n1",   32'(busy),   32'd1);
    check("src_cs_n1", 32'(src_cs), 32'd0);
    @(posedge clk);
    cyc = 2;
    @(negedge clk);
    check("src_cs_n2",      32'(src_cs),   32'd1);
    check("src_addr_first", 32'(src_addr), 32'(BASE));
    while (!done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("done_latency", 32'(cyc), 32'd2050);
    repeat (3) @(negedge clk);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_writes",     32'(wr_cnt),   32'd1024);
    check("t1_done_pulse", 32'(done),     32'd0);
    check("t1_busy_idle",  32'(busy),     32'd0);

    // Armed outside blank: no request for 500 clocks, stray src_ok ignored
    LVBL = 1'b1;
    spurious = 1'b1;
    arm();
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (src_cs || pal_we) bad++;
    end
    check("t2_no_req_outside_blank", 32'(bad),    32'd0);
    check("t2_busy_waiting",         32'(busy),   32'd1);
    check("t2_no_writes",            32'(wr_cnt), 32'd0);
    spurious = 1'b0;
    LVBL = 1'b0;
    wait_done(3000, "t2");
    repeat (3) @(negedge clk);
    check("t2_done_count", 32'(done_cnt), 32'd2);
    check("t2_writes",     32'(wr_cnt),   32'd1024);

    // Blank ends while request for index 300 is pending
    dly = 5;
    arm();
    cyc = 0;
    while (!(src_cs && src_addr == SRC_AW'(BASE + 17'd300)) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_reached_300", 32'(src_cs && src_addr == SRC_AW'(BASE + 17'd300)), 32'd1);
    LVBL = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_write_300_done", 32'(wr_cnt), 32'd301);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (src_cs) bad++;
    end
    check("t3_paused_no_req", 32'(bad),  32'd0);
    check("t3_paused_busy",   32'(busy), 32'd1);
    LVBL = 1'b0;
    wait_done(20000, "t3");
    repeat (3) @(negedge clk);
    check("t3_done_count", 32'(done_cnt), 32'd3);
    check("t3_writes",     32'(wr_cnt),   32'd1024);
    dly = 0;

    // dma_go while busy is ignored
    arm();
    cyc = 0;
    while (wr_cnt < 600 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    dma_go = 1'b1;
    @(negedge clk);
    dma_go = 1'b0;
    d0 = done_cnt;
    wait_done(3000, "t4");
    repeat (20) @(negedge clk);
    check("t4_single_done", 32'(done_cnt - d0), 32'd1);
    check("t4_writes",      32'(wr_cnt),        32'd1024);
    check("t4_idle_busy",   32'(busy),          32'd0);

    // Asynchronous reset mid-transfer
    arm();
    cyc = 0;
    while (wr_cnt < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    d0 = done_cnt;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_src_addr", 32'(src_addr), 32'(BASE));
    check("t5_src_cs",   32'(src_cs),   32'd0);
    check("t5_pal_addr", 32'(pal_addr), 32'd0);
    check("t5_pal_dout", 32'(pal_dout), 32'd0);
    check("t5_pal_we",   32'(pal_we),   32'd0);
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_done",     32'(done),     32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_idle_busy",   32'(busy),          32'd0);
    check("t5_idle_src_cs", 32'(src_cs),        32'd0);
    check("t5_no_done",     32'(done_cnt - d0), 32'd0);

    // Fresh transfer after reset recovers fully
    arm();
    wait_done(3000, "t6");
    repeat (3) @(negedge clk);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);
    check("t6_writes",     32'(wr_cnt),        32'd1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkiwi_paldma.md
# jtkiwi_paldma

Palette upload engine for the Kiwi video path: copies a full palette image from a staging memory into the palette RAM write port during vertical blank. Armed by a CPU strobe, it reads source bytes through a request/ok handshake and drives the palette RAM CPU-side port, the write end of the RAM the colour mixer reads. It pauses outside vertical blank so visible lines never see a half-updated palette.

## Interface
Parameters:
- AW, 10, palette address width; transfer length is 2**AW bytes
- SRC_AW, 17, source memory address width
- SRC_BASE, 0, source address of palette byte 0 (SRC_AW bits)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- LVBL  in  1  vertical blank, active low (0 = blanking)
- dma_go  in  1  one-cycle arm strobe from CPU decoder
- src_addr  out  SRC_AW  source byte address, SRC_BASE + index
- src_cs  out  1  source read request, held until src_ok
- src_ok  in  1  source data valid this cycle
- src_data  in  8  source byte, sampled when src_cs & src_ok
- pal_addr  out  AW  palette RAM write address
- pal_dout  out  8  palette RAM write data
- pal_we  out  1  palette RAM write enable, one cycle per byte
- busy  out  1  high from arm until completion
- done  out  1  one-cycle pulse after last byte written

## Operation
- States: IDLE, ARMED, READ, WRITE, DONE. Internal index counter cnt, AW+1 bits.
- IDLE: busy=0. dma_go -> ARMED, cnt=0.
- ARMED: busy=1. If LVBL==0 -> READ; else wait.
- READ: src_cs=1, src_addr=SRC_BASE+cnt (zero-extended cnt, sum truncated to SRC_AW, wraps). On src_ok: latch src_data into pal_dout, pal_addr<=cnt[AW-1:0], -> WRITE.
- WRITE: pal_we=1 for exactly one cycle; cnt<=cnt+1. If cnt was 2**AW-1 -> DONE; else if LVBL==0 -> READ; else -> ARMED (paused, resumes at same cnt).
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- LVBL rising during READ: in-flight request held until src_ok and its write completes; no new request issued until LVBL returns low.
- dma_go while busy: ignored, transfer not restarted, cnt unchanged.
- dma_go in the DONE cycle: ignored.
- src_ok while src_cs=0: ignored.
- pal_addr/pal_dout hold last values outside WRITE; only pal_we qualifies them.

## Timing
- Reset values: src_addr=SRC_BASE, src_cs=0, pal_addr=0, pal_dout=0, pal_we=0, busy=0, done=0, state IDLE, cnt=0.
- Reset asserted mid-transfer: all outputs return to reset values asynchronously; no write completes; no done pulse.
- dma_go at edge N with LVBL=0: busy=1 at N+1, src_cs=1 at N+2.
- src_ok at edge M: pal_we=1 during cycle M+1; next src_cs at M+2 if in blank.
- Throughput with zero-wait source (src_ok same cycle as src_cs): one byte per 2 clocks; 2**AW=1024 bytes take 2048 clocks from first READ to DONE.
- done asserted the cycle after the final pal_we; busy falls together with done's assertion.
- src_cs, src_addr registered; stable while waiting for src_ok.

## Configuration
- JTKIWI_PALDMA_CHKSUM_EN defined: adds output chksum [7:0]; cleared to 0 on reset and on each accepted dma_go; adds each written byte modulo 256 on its pal_we cycle; valid and stable from the done pulse until next arm.
- Undefined: no chksum port, no adder; all other behaviour identical.

## Test plan
- Full copy, LVBL=0 throughout, source byte[i]=i[7:0], zero-wait: 1024 pal_we pulses, pal_addr 0..1023, pal_dout=i[7:0], done at 2048+2 clocks after dma_go; chksum=0x00 with macro.
- Arm with LVBL=1 for 500 clocks then LVBL=0: src_cs stays 0 for 500 clocks, first write to pal_addr 0 after blank begins.
- LVBL rises while src_cs waits (src_ok delayed 5 clocks) at cnt=300: write to address 300 still occurs, no request at cnt=301 until LVBL=0, then resumes at 301; no address skipped or repeated.
- dma_go pulsed at cnt=600: no restart, final write still at 1023, exactly one done pulse.
- rst_n low at cnt=100: all outputs reset immediately; after release, pal_we stays 0 until a new dma_go.
- SRC_BASE=0x1FF00, SRC_AW=17: src_addr runs 0x1FF00..0x1FFFF then wraps to 0x00000..0x002FF.
